// File: rtl/snow64_ex_unit_sequencer.sv
// snow64_ex_unit_sequencer
// Execute-stage sequencer: accepts one decoded operation over a valid/ready
// handshake, dispatches it to one of NUM_UNITS functional units, waits for the
// unit's completion and holds the result until downstream takes it.
//
// Optional feature macro: SNOW64_EX_SEQ_TIMEOUT_EN
//   defined   -> completion watchdog in WAIT, TIMEOUT_CYCLES limit
//   undefined -> WAIT is unbounded; out_error only flags an invalid selector
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      operation handshake from IF/ID
//   in_unit_sel, in_oper     target unit, opcode
//   in_operand_a/b, in_tag   operands, destination tag
//   out_unit_start           one-hot start pulse (1 cycle)
//   out_unit_oper/a/b        latched opcode and operands to the units
//   in_unit_done             per-unit completion strobe
//   in_unit_result           per-unit result, unit u at [u*DATA_WIDTH +: DATA_WIDTH]
//   out_valid / out_ready    result handshake to downstream
//   out_result, out_tag      captured result and its tag
//   out_error                invalid selector or watchdog timeout
//
// state    | meaning
// IDLE     | no operation in flight, ready to accept
// DISPATCH | start pulse to the selected unit (one cycle)
// WAIT     | waiting for the selected unit's done strobe
// HOLD     | result presented until out_ready
`timescale 1ns/1ps

module snow64_ex_unit_sequencer #(
    parameter int                   NUM_UNITS      = 4,
    parameter int                   UNIT_SEL_WIDTH = 3,
    parameter int                   DATA_WIDTH     = 256,
    parameter int                   OPER_WIDTH     = 5,
    parameter int                   TAG_WIDTH      = 4,
    parameter logic [NUM_UNITS-1:0] ZERO_LAT_MASK  = 4'b0001,
    parameter int                   TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [UNIT_SEL_WIDTH-1:0]       in_unit_sel,
    input  logic [OPER_WIDTH-1:0]           in_oper,
    input  logic [DATA_WIDTH-1:0]           in_operand_a,
    input  logic [DATA_WIDTH-1:0]           in_operand_b,
    input  logic [TAG_WIDTH-1:0]            in_tag,
    output logic [NUM_UNITS-1:0]            out_unit_start,
    output logic [OPER_WIDTH-1:0]           out_unit_oper,
    output logic [DATA_WIDTH-1:0]           out_unit_a,
    output logic [DATA_WIDTH-1:0]           out_unit_b,
    input  logic [NUM_UNITS-1:0]            in_unit_done,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] in_unit_result,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_result,
    output logic [TAG_WIDTH-1:0]            out_tag,
    output logic                            out_error
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_WAIT     = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;

    logic [OPER_WIDTH-1:0]     r_oper;
    logic [DATA_WIDTH-1:0]     r_a;
    logic [DATA_WIDTH-1:0]     r_b;
    logic [TAG_WIDTH-1:0]      r_tag;
    logic [UNIT_SEL_WIDTH-1:0] r_sel;
    logic [DATA_WIDTH-1:0]     r_result;
    logic                      r_error;

    logic                      w_accept;
    logic                      w_in_invalid;
    logic                      w_sel_done;
    logic                      w_sel_zero_lat;
    logic [DATA_WIDTH-1:0]     w_sel_result;
    logic                      w_timeout;

    assign in_ready     = !rst && ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready));
    assign w_accept     = in_valid && in_ready;
    assign w_in_invalid = (32'(in_unit_sel) >= 32'(NUM_UNITS));

    // Mux the latched unit's channel by loop compare so an out-of-range
    // selector never forms an out-of-range part-select.
    always_comb begin
        w_sel_done     = 1'b0;
        w_sel_zero_lat = 1'b0;
        w_sel_result   = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (r_sel == UNIT_SEL_WIDTH'(u)) begin
                w_sel_done     = in_unit_done[u];
                w_sel_zero_lat = ZERO_LAT_MASK[u];
                w_sel_result   = in_unit_result[u*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef SNOW64_EX_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_wd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if (r_state == ST_DISPATCH) begin
            r_wd_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_WAIT) && (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_in_invalid ? ST_HOLD : ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                w_next_state = w_sel_zero_lat ? ST_HOLD : ST_WAIT;
            end
            ST_WAIT: begin
                // A done in the expiry cycle takes precedence over the timeout.
                if (w_sel_done || w_timeout) begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_accept) begin
                    w_next_state = w_in_invalid ? ST_HOLD : ST_DISPATCH;
                end else if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Operation latch and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_oper   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_tag    <= '0;
            r_sel    <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
        end else if (w_accept) begin
            r_oper <= in_oper;
            r_a    <= in_operand_a;
            r_b    <= in_operand_b;
            r_tag  <= in_tag;
            r_sel  <= in_unit_sel;
            if (w_in_invalid) begin
                r_result <= '0;
                r_error  <= 1'b1;
            end
        end else if ((r_state == ST_DISPATCH) && w_sel_zero_lat) begin
            r_result <= w_sel_result;
            r_error  <= 1'b0;
        end else if (r_state == ST_WAIT) begin
            if (w_sel_done) begin
                r_result <= w_sel_result;
                r_error  <= 1'b0;
            end else if (w_timeout) begin
                r_result <= '0;
                r_error  <= 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        out_valid      = (r_state == ST_HOLD);
        out_unit_start = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            out_unit_start[u] = (r_state == ST_DISPATCH) && (r_sel == UNIT_SEL_WIDTH'(u));
        end
    end

    assign out_unit_oper = r_oper;
    assign out_unit_a    = r_a;
    assign out_unit_b    = r_b;
    assign out_result    = r_result;
    assign out_tag       = r_tag;
    assign out_error     = r_error;

endmodule

// File: doc/snow64_ex_unit_sequencer.md
# snow64_ex_unit_sequencer

Parametrised execute-stage sequencer for Snow64. It accepts one decoded operation at a time from the IF/ID stage over a valid/ready handshake and dispatches it to one of NUM_UNITS functional-unit channels (vector ALU, multiplier, divider, BFloat16 FPU, and further units). It waits for that unit's completion, then holds the result for downstream until it is taken. It handles both zero-latency (combinational) and multi-cycle units, with an optional completion watchdog.

## Interface
- NUM_UNITS, 4: number of functional-unit channels.
- UNIT_SEL_WIDTH, 3: width of the unit selector; must hold NUM_UNITS−1 plus at least one out-of-range code.
- DATA_WIDTH, 256: operand and result width (one LAR data line).
- OPER_WIDTH, 5: opcode width, passed through to the units.
- TAG_WIDTH, 4: destination tag width, passed through to the result.
- ZERO_LAT_MASK, 4'b0001: bit u set means unit u is combinational (result valid in the start cycle).
- TIMEOUT_CYCLES, 64: watchdog limit in WAIT; must be at least 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  sequencer accepts this cycle.
- in_unit_sel  in  UNIT_SEL_WIDTH  target unit.
- in_oper  in  OPER_WIDTH  opcode.
- in_operand_a, in_operand_b  in  DATA_WIDTH  operands.
- in_tag  in  TAG_WIDTH  destination tag.
- out_unit_start  out  NUM_UNITS  one-hot start pulse.
- out_unit_oper  out  OPER_WIDTH  latched opcode to the units.
- out_unit_a, out_unit_b  out  DATA_WIDTH  latched operands to the units.
- in_unit_done  in  NUM_UNITS  per-unit completion strobe.
- in_unit_result  in  NUM_UNITS*DATA_WIDTH  per-unit result; unit u occupies bits [u*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  result available.
- out_ready  in  1  downstream takes the result.
- out_result  out  DATA_WIDTH  captured result.
- out_tag  out  TAG_WIDTH  tag of the result.
- out_error  out  1  set for an invalid selector or a timeout.

## Operation
- States: IDLE, DISPATCH, WAIT, HOLD.
- in_ready = !rst && (IDLE || (HOLD && out_ready)).
- Accept (in_valid && in_ready):
  - Latch oper, operands, tag and sel.
  - If sel ≥ NUM_UNITS: go to HOLD with result 0 and out_error=1. No start pulse is issued.
  - Otherwise go to DISPATCH.
- DISPATCH (exactly 1 cycle): out_unit_start[sel]=1.
  - Zero-latency unit: capture in_unit_result[sel] this cycle, out_error=0, go to HOLD.
  - Otherwise clear the watchdog counter and go to WAIT. in_unit_done is ignored during DISPATCH.
- WAIT:
  - On in_unit_done[sel]: capture the result, out_error=0, go to HOLD.
  - done strobes from other units are ignored.
  - On watchdog expiry (see Configuration): result 0, out_error=1, go to HOLD.
- HOLD: out_valid=1, and out_result, out_tag and out_error are stable.
  - On out_ready: if in_valid is also high, accept the new operation (back-to-back). Otherwise go to IDLE.
- out_unit_oper, out_unit_a and out_unit_b hold their latched values from acceptance until the next acceptance.
- Reset, including mid-operation: state=IDLE. All outputs are 0 (out_valid, out_unit_start, out_result, out_tag, out_error, out_unit_*). The in-flight operation is abandoned and never re-issued. A late in_unit_done arriving in IDLE is ignored.

## Timing
- Zero-latency unit: accept at cycle T, start and capture at T+1, out_valid from T+2.
- Multi-cycle unit with done at cycle D (D ≥ T+2): out_valid from D+1.
- Invalid selector: out_valid at T+1.
- Throughput: one operation per (latency + 2) cycles. HOLD-to-accept adds no bubble.
- The start pulse is never longer than 1 cycle. At most one operation is in flight.

## Configuration
- SNOW64_EX_SEQ_TIMEOUT_EN defined:
  - The watchdog counter has width $clog2(TIMEOUT_CYCLES) and increments every WAIT cycle.
  - If the counter reaches TIMEOUT_CYCLES−1 with no done, the sequencer exits to HOLD with out_error=1.
  - A done arriving in that same cycle wins: the result is captured and out_error=0.
- SNOW64_EX_SEQ_TIMEOUT_EN undefined:
  - No counter exists; WAIT is unbounded.
  - out_error is set only for an invalid selector.

## Test plan
- After reset release, in_ready=1. Send sel=0 (zero-latency), unit 0 result 0x1234 -> out_unit_start=4'b0001 for 1 cycle at T+1; out_valid at T+2 with out_result=0x1234 and out_error=0.
- Send sel=2; assert in_unit_done[2] at T+6 with result 0xABCD, and in_unit_done[1] at T+4 -> unit 1's done is ignored; out_valid at T+7 with 0xABCD and the correct tag.
- Hold out_ready=0 for 5 cycles in HOLD -> out_valid and out_result stay stable and in_ready=0. Then raise out_ready together with in_valid -> the new operation is accepted in the same cycle.
- Send sel=5 (invalid) -> no start pulse; out_valid at T+1 with out_error=1 and out_result=0.
- With the macro defined: send sel=3 and never assert done -> out_error=1 after 64 WAIT cycles. With the macro undefined: still waiting after 200 cycles.
- Assert rst during WAIT, then deliver in_unit_done after release -> outputs 0, IDLE, in_ready=1, and no out_valid is produced.
